// File: rtl/cordic_arbiter_if.sv
// Requester and CORDIC-side signal bundle for cordic_arbiter.
// slave is the arbiter side; master is the environment side.
interface cordic_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 16
);
    logic [NREQ-1:0]        req;
    logic [NREQ*DATA_W-1:0] req_x;
    logic [NREQ*DATA_W-1:0] req_y;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_angle;
    logic [DATA_W-1:0]      rsp_mag;
    logic                   rsp_err;
    logic [7:0]             err_count;
    logic                   cor_start;
    logic [DATA_W-1:0]      cor_x;
    logic [DATA_W-1:0]      cor_y;
    logic                   cor_done;
    logic                   cor_busy;
    logic [DATA_W-1:0]      cor_angle;
    logic [DATA_W-1:0]      cor_mag;

    modport slave (
        input  req, req_x, req_y,
        input  cor_done, cor_busy, cor_angle, cor_mag,
        output gnt, rsp_valid, rsp_angle, rsp_mag,
        output rsp_err, err_count,
        output cor_start, cor_x, cor_y
    );

    modport master (
        output req, req_x, req_y,
        output cor_done, cor_busy, cor_angle, cor_mag,
        input  gnt, rsp_valid, rsp_angle, rsp_mag,
        input  rsp_err, err_count,
        input  cor_start, cor_x, cor_y
    );
endinterface

// File: rtl/cordic_arbiter.sv
// Round-robin sequencer sharing one CORDIC vectoring unit among NREQ
// requesters, with a per-job watchdog and one-hot result routing.
module cordic_arbiter #(
    parameter int NREQ           = 3,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    cordic_arbiter_if.slave  bus
);
    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW1 = PW + 1;
    localparam int CW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_owner;
    logic [CW-1:0]   r_cnt;
    logic [NREQ-1:0] w_rot;
    logic [PW-1:0]   w_off;
    logic [PW:0]     w_sum;
    logic [PW-1:0]   w_pick;
    logic [PW-1:0]   w_ptr_nxt;
    logic            w_found;
    logic            w_grant;
    logic            w_done;
    logic            w_tmo;
    logic [NREQ-1:0] w_own_oh;
    logic [DATA_W-1:0] w_opx;
    logic [DATA_W-1:0] w_opy;

    // Rotate so bit 0 is the requester at ptr; lowest set bit wins.
    always_comb begin
        w_rot   = NREQ'({bus.req, bus.req} >> r_ptr);
        w_found = 1'b0;
        w_off   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_off   = PW'(k);
            end
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= PW1'(NREQ)) begin
            w_pick = PW'(w_sum - PW1'(NREQ));
        end else begin
            w_pick = w_sum[PW-1:0];
        end
        w_ptr_nxt = (w_pick == PW'(NREQ - 1)) ? '0 : w_pick + PW'(1);
        w_own_oh  = NREQ'(1) << r_owner;
        w_opx = '0;
        w_opy = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick == PW'(i)) begin
                w_opx = bus.req_x[i*DATA_W +: DATA_W];
                w_opy = bus.req_y[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_found && !bus.cor_busy) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.cor_done) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr         <= '0;
            r_owner       <= '0;
            r_cnt         <= '0;
            bus.gnt       <= '0;
            bus.cor_start <= 1'b0;
            bus.cor_x     <= '0;
            bus.cor_y     <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_angle <= '0;
            bus.rsp_mag   <= '0;
            bus.rsp_err   <= 1'b0;
            bus.err_count <= '0;
        end else begin
            bus.gnt       <= '0;
            bus.cor_start <= 1'b0;
            bus.rsp_valid <= '0;
            if (w_grant) begin
                r_owner       <= w_pick;
                r_ptr         <= w_ptr_nxt;
                bus.gnt       <= NREQ'(1) << w_pick;
                bus.cor_start <= 1'b1;
                bus.cor_x     <= w_opx;
                bus.cor_y     <= w_opy;
            end
            if (r_state == S_ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + CW'(1);
            end
            // A done on the terminal count takes priority over the timeout.
            if (w_done) begin
                bus.rsp_valid <= w_own_oh;
                bus.rsp_angle <= bus.cor_angle;
                bus.rsp_mag   <= bus.cor_mag;
                bus.rsp_err   <= 1'b0;
            end else if (w_tmo) begin
                bus.rsp_valid <= w_own_oh;
                bus.rsp_angle <= '0;
                bus.rsp_mag   <= '0;
                bus.rsp_err   <= 1'b1;
                if (bus.err_count != 8'hFF) begin
                    bus.err_count <= bus.err_count + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed/randomized bench for cordic_arbiter with a behavioural CORDIC
// model and a round-robin reference pointer kept in the bench.
module tb_cordic_arbiter;
    localparam int NREQ = 3;
    localparam int DW   = 16;
    localparam int TMO  = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    cordic_arbiter_if #(.NREQ(NREQ), .DATA_W(DW)) bus ();

    cordic_arbiter #(
        .NREQ(NREQ), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rr_ptr  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // CORDIC model: done pulses m_lat cycles after the start cycle.
    int  m_lat = 14;
    bit  m_hang = 1'b0;
    bit  f_busy = 1'b0;
    int  m_cnt = 0;
    int  m_stray_req = 0;
    int  m_stray_ack = 0;
    logic [DW-1:0] m_x, m_y;

    function automatic logic [DW-1:0] f_ang(input logic [DW-1:0] x, input logic [DW-1:0] y);
        return x - y;
    endfunction
    function automatic logic [DW-1:0] f_mag(input logic [DW-1:0] x, input logic [DW-1:0] y);
        return x + y;
    endfunction

    assign bus.cor_busy = f_busy | (m_cnt > 0);

    always @(negedge clk) begin
        bus.cor_done = 1'b0;
        if (bus.cor_start === 1'b1) begin
            m_x   = bus.cor_x;
            m_y   = bus.cor_y;
            m_cnt = m_hang ? 0 : m_lat;
        end else if (m_cnt > 0) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                bus.cor_done  = 1'b1;
                bus.cor_angle = f_ang(m_x, m_y);
                bus.cor_mag   = f_mag(m_x, m_y);
            end
        end
        if (m_stray_req != m_stray_ack) begin
            bus.cor_done = 1'b1;
            m_stray_ack  = m_stray_req;
        end
    end

    logic [DW-1:0] ox [NREQ];
    logic [DW-1:0] oy [NREQ];

    task automatic put_ops();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_x[i*DW +: DW] = ox[i];
            bus.req_y[i*DW +: DW] = oy[i];
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int oh2i(input logic [NREQ-1:0] v);
        int r;
        r = -2;
        if ($countones(v) != 1) return -2;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic wait_gnt(input string tag, input int budget, output int idx, output int at);
        idx = -1;
        at  = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.gnt != '0) begin
                at  = cyc;
                idx = oh2i(bus.gnt);
                break;
            end
        end
        if (at < 0) chk({tag, " gnt_seen"}, 32'(at >= 0), 32'd1);
    endtask

    task automatic wait_rsp(input string tag, input int budget,
                            output logic [NREQ-1:0] rv, output int at);
        rv = '0;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.rsp_valid != '0) begin
                at = cyc;
                rv = bus.rsp_valid;
                break;
            end
        end
        if (at < 0) chk({tag, " rsp_seen"}, 32'(at >= 0), 32'd1);
    endtask

    task automatic no_evt(input string tag, input int n, input bit use_gnt);
        int hits;
        hits = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (use_gnt ? (bus.gnt != '0) : (bus.rsp_valid != '0)) hits++;
        end
        chk(tag, 32'(hits), 32'd0);
    endtask

    task automatic run_job(input string tag, input int lat, input bit drop, output int g_at);
        int exp, idx, r_at;
        logic [DW-1:0] ex, ey;
        logic [NREQ-1:0] rv;
        m_lat = lat;
        exp = rr_pick(bus.req, rr_ptr);
        if (exp < 0) exp = 0;
        wait_gnt(tag, 300, idx, g_at);
        chk({tag, " gnt_idx"}, 32'(idx), 32'(exp));
        ex = ox[exp];
        ey = oy[exp];
        chk({tag, " cor_x"}, 32'(bus.cor_x), 32'(ex));
        chk({tag, " cor_y"}, 32'(bus.cor_y), 32'(ey));
        chk({tag, " cor_start"}, 32'(bus.cor_start), 32'd1);
        rr_ptr = (exp + 1) % NREQ;
        if (drop) bus.req[exp] = 1'b0;
        @(negedge clk);
        chk({tag, " start_pulse"}, 32'({bus.cor_start, bus.gnt}), 32'd0);
        ox[exp] = 16'($urandom);
        oy[exp] = 16'($urandom);
        put_ops();
        wait_rsp(tag, 300, rv, r_at);
        chk({tag, " rsp_valid"}, 32'(rv), 32'(1 << exp));
        chk({tag, " rsp_cycle"}, 32'(r_at), 32'(g_at + lat + 1));
        chk({tag, " rsp_err"}, 32'(bus.rsp_err), 32'd0);
        chk({tag, " angle"}, 32'(bus.rsp_angle), 32'(f_ang(ex, ey)));
        chk({tag, " mag"}, 32'(bus.rsp_mag), 32'(f_mag(ex, ey)));
    endtask

    task automatic tmo_job(input string tag, input bit drop, output int g_at);
        int exp, idx, r_at;
        logic [NREQ-1:0] rv;
        exp = rr_pick(bus.req, rr_ptr);
        if (exp < 0) exp = 0;
        wait_gnt(tag, 300, idx, g_at);
        chk({tag, " gnt_idx"}, 32'(idx), 32'(exp));
        rr_ptr = (exp + 1) % NREQ;
        if (drop) bus.req[exp] = 1'b0;
        wait_rsp(tag, TMO + 20, rv, r_at);
        chk({tag, " rsp_valid"}, 32'(rv), 32'(1 << exp));
        chk({tag, " rsp_cycle"}, 32'(r_at), 32'(g_at + TMO + 1));
        chk({tag, " rsp_err"}, 32'(bus.rsp_err), 32'd1);
        chk({tag, " zero_res"}, 32'({bus.rsp_angle, bus.rsp_mag}), 32'd0);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        bus.req  = '0;
        m_hang   = 1'b0;
        f_busy   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        rr_ptr = 0;
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int g, t0, idx;
        bus.req = '0;
        for (int i = 0; i < NREQ; i++) begin
            ox[i] = '0;
            oy[i] = '0;
        end
        put_ops();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst gnt", 32'(bus.gnt), 32'd0);
        chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst start_err", 32'({bus.cor_start, bus.rsp_err}), 32'd0);
        chk("rst err_count", 32'(bus.err_count), 32'd0);
        chk("rst cor_xy", {bus.cor_x, bus.cor_y}, 32'd0);
        chk("rst rsp", {bus.rsp_angle, bus.rsp_mag}, 32'd0);
        rst_n  = 1'b1;
        rr_ptr = 0;
        @(negedge clk);

        ox[0] = 16'd1000;
        oy[0] = 16'd1000;
        put_ops();
        bus.req = 3'b001;
        t0 = cyc;
        run_job("single", 14, 1'b1, g);
        chk("single gnt_cycle", 32'(g), 32'(t0 + 1));

        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            ox[i] = 16'($urandom);
            oy[i] = 16'($urandom);
        end
        put_ops();
        bus.req = 3'b111;
        for (int j = 0; j < 6; j++) begin
            run_job("rr", int'($urandom_range(2, 20)), 1'b0, g);
        end
        bus.req = '0;
        repeat (3) @(negedge clk);

        m_hang  = 1'b1;
        bus.req = 3'b010;
        tmo_job("tmo", 1'b1, g);
        chk("tmo err_count", 32'(bus.err_count), 32'd1);
        @(negedge clk);
        chk("tmo hold", 32'({bus.rsp_valid, bus.rsp_err}), 32'd1);
        bus.req = 3'b010;
        for (int n = 2; n <= 300; n++) begin
            tmo_job("tmo_sat", 1'b0, g);
            if (n == 254 || n == 256) begin
                chk("tmo count", 32'(bus.err_count), 32'(n == 254 ? 254 : 255));
            end
        end
        bus.req = '0;
        chk("tmo saturated", 32'(bus.err_count), 32'd255);
        m_hang = 1'b0;
        repeat (3) @(negedge clk);

        do_reset();
        ox[0] = 16'($urandom);
        oy[0] = 16'($urandom);
        put_ops();
        bus.req = 3'b001;
        run_job("edge64", TMO, 1'b1, g);
        chk("edge64 err_count", 32'(bus.err_count), 32'd0);
        m_lat   = TMO + 1;
        bus.req = 3'b001;
        tmo_job("edge65", 1'b1, g);
        chk("edge65 err_count", 32'(bus.err_count), 32'd1);
        no_evt("late done ignored", 10, 1'b0);
        m_stray_req++;
        no_evt("stray done", 10, 1'b0);

        f_busy = 1'b1;
        ox[2] = 16'($urandom);
        oy[2] = 16'($urandom);
        put_ops();
        bus.req = 3'b100;
        no_evt("busy no gnt", 10, 1'b1);
        f_busy = 1'b0;
        t0 = cyc;
        run_job("busy", 20, 1'b1, g);
        chk("busy gnt_cycle", 32'(g), 32'(t0 + 1));

        m_lat = 30;
        ox[0] = 16'($urandom) | 16'h1;
        oy[0] = 16'($urandom);
        put_ops();
        bus.req = 3'b001;
        wait_gnt("rst_mid", 300, idx, g);
        chk("rst_mid gnt_idx", 32'(idx), 32'(rr_pick(3'b001, rr_ptr)));
        bus.req = '0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async gnt_rsp", 32'({bus.gnt, bus.rsp_valid}), 32'd0);
        chk("async start_err", 32'({bus.cor_start, bus.rsp_err}), 32'd0);
        chk("async err_count", 32'(bus.err_count), 32'd0);
        chk("async cor_xy", {bus.cor_x, bus.cor_y}, 32'd0);
        chk("async rsp", {bus.rsp_angle, bus.rsp_mag}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        rr_ptr = 0;
        no_evt("post-reset done", 40, 1'b0);
        ox[0] = 16'($urandom);
        ox[2] = 16'($urandom);
        put_ops();
        bus.req = 3'b101;
        run_job("after_rst first", 10, 1'b1, g);
        run_job("after_rst second", 10, 1'b1, g);
        chk("after_rst ptr", 32'(rr_ptr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
